// File: rtl/pipe_stage_skid.sv
// Registered valid/ready pipeline stage for a writeback bundle (addr, wreg, data, aux)
// with a one-entry skid buffer so in_ready is a pure register, plus flush and occupancy.
module pipe_stage_skid #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned AUX_W         = 8,
    parameter bit          ZERO_ON_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic              in_wreg,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [AUX_W-1:0]  in_aux,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_wd,
    output logic              out_wreg,
    output logic [DATA_W-1:0] out_wdata,
    output logic [AUX_W-1:0]  out_aux,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_LOAD_IN   = 2'd1,
        MAIN_LOAD_SKID = 2'd2,
        MAIN_CLEAR     = 2'd3
    } main_op_t;

    state_t             r_state;
    state_t             w_nxt_state;
    main_op_t           w_main_op;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_accept;
    logic               w_drain;

    logic               r_in_ready;
    logic               r_out_valid;

    logic [ADDR_W-1:0]  r_main_wd;
    logic               r_main_wreg;
    logic [DATA_W-1:0]  r_main_wdata;
    logic [AUX_W-1:0]   r_main_aux;

    logic [ADDR_W-1:0]  r_skid_wd;
    logic               r_skid_wreg;
    logic [DATA_W-1:0]  r_skid_wdata;
    logic [AUX_W-1:0]   r_skid_aux;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic; flush overrides every handshake
    always_comb begin
        w_nxt_state = r_state;
        if (flush) begin
            w_nxt_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_nxt_state = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        w_nxt_state = ST_FULL;
                    end else if (!w_accept && w_drain) begin
                        w_nxt_state = ST_EMPTY;
                    end
                end
                ST_FULL:  if (w_drain) w_nxt_state = ST_ONE;
                default:  w_nxt_state = ST_EMPTY;
            endcase
        end
    end

    // Datapath steering for the main and skid registers
    always_comb begin
        w_main_op    = MAIN_HOLD;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush) begin
            w_main_op    = MAIN_CLEAR;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_main_op = MAIN_LOAD_IN;
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_op = MAIN_LOAD_IN;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                    end else if (w_drain) begin
                        w_main_op = MAIN_CLEAR;
                    end
                end
                ST_FULL:  if (w_drain) w_main_op = MAIN_LOAD_SKID;
                default:  w_main_op = MAIN_CLEAR;
            endcase
        end
    end

    // Handshake flags registered from the next state so neither has a comb input path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_nxt_state != ST_FULL);
            r_out_valid <= (w_nxt_state != ST_EMPTY);
        end
    end

    // Main register; on emptying, wreg always drops, the rest only when zeroing is enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_wd    <= '0;
            r_main_wreg  <= 1'b0;
            r_main_wdata <= '0;
            r_main_aux   <= '0;
        end else begin
            case (w_main_op)
                MAIN_LOAD_IN: begin
                    r_main_wd    <= in_wd;
                    r_main_wreg  <= in_wreg;
                    r_main_wdata <= in_wdata;
                    r_main_aux   <= in_aux;
                end
                MAIN_LOAD_SKID: begin
                    r_main_wd    <= r_skid_wd;
                    r_main_wreg  <= r_skid_wreg;
                    r_main_wdata <= r_skid_wdata;
                    r_main_aux   <= r_skid_aux;
                end
                MAIN_CLEAR: begin
                    r_main_wreg <= 1'b0;
                    if (ZERO_ON_EMPTY) begin
                        r_main_wd    <= '0;
                        r_main_wdata <= '0;
                        r_main_aux   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Skid register catches the beat accepted while the main entry is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_wd    <= '0;
            r_skid_wreg  <= 1'b0;
            r_skid_wdata <= '0;
            r_skid_aux   <= '0;
        end else if (w_skid_clear) begin
            r_skid_wd    <= '0;
            r_skid_wreg  <= 1'b0;
            r_skid_wdata <= '0;
            r_skid_aux   <= '0;
        end else if (w_skid_load) begin
            r_skid_wd    <= in_wd;
            r_skid_wreg  <= in_wreg;
            r_skid_wdata <= in_wdata;
            r_skid_aux   <= in_aux;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_wd    = r_main_wd;
    assign out_wreg  = r_main_wreg;
    assign out_wdata = r_main_wdata;
    assign out_aux   = r_main_aux;
    assign occupancy = 2'(r_state);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + scoreboard bench for pipe_stage_skid: default and hold-on-empty instances share
// stimulus; a wide instance runs a random valid/ready stream against a FIFO scoreboard.
module tb_pipe_stage_skid;

    localparam int unsigned XD = 64;
    localparam int unsigned XA = 6;
    localparam int unsigned XX = 1;

    typedef logic [45:0] beat0_t;
    typedef logic [71:0] beat2_t;

    logic clk;
    logic rst;

    logic        flush;
    logic        in_valid;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_wdata;
    logic [7:0]  in_aux;
    logic        out_ready;

    logic        o0_in_ready, o0_out_valid, o0_out_wreg;
    logic [4:0]  o0_out_wd;
    logic [31:0] o0_out_wdata;
    logic [7:0]  o0_out_aux;
    logic [1:0]  o0_occ;

    logic        o1_in_ready, o1_out_valid, o1_out_wreg;
    logic [4:0]  o1_out_wd;
    logic [31:0] o1_out_wdata;
    logic [7:0]  o1_out_aux;
    logic [1:0]  o1_occ;

    logic          x_flush;
    logic          x_in_valid, x_in_ready, x_in_wreg;
    logic [XA-1:0] x_in_wd;
    logic [XD-1:0] x_in_wdata;
    logic [XX-1:0] x_in_aux;
    logic          x_out_valid, x_out_ready, x_out_wreg;
    logic [XA-1:0] x_out_wd;
    logic [XD-1:0] x_out_wdata;
    logic [XX-1:0] x_out_aux;
    logic [1:0]    x_occ;

    int n_checks = 0;
    int n_fail   = 0;
    int n2_sent  = 0;
    int n2_recv  = 0;

    beat0_t q0[$];
    beat2_t q2[$];

    pipe_stage_skid u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_aux(in_aux),
        .out_valid(o0_out_valid), .out_ready(out_ready),
        .out_wd(o0_out_wd), .out_wreg(o0_out_wreg), .out_wdata(o0_out_wdata), .out_aux(o0_out_aux),
        .occupancy(o0_occ)
    );

    pipe_stage_skid #(.ZERO_ON_EMPTY(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_aux(in_aux),
        .out_valid(o1_out_valid), .out_ready(out_ready),
        .out_wd(o1_out_wd), .out_wreg(o1_out_wreg), .out_wdata(o1_out_wdata), .out_aux(o1_out_aux),
        .occupancy(o1_occ)
    );

    pipe_stage_skid #(.DATA_W(XD), .ADDR_W(XA), .AUX_W(XX)) u_dut2 (
        .clk(clk), .rst(rst), .flush(x_flush),
        .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_wd(x_in_wd), .in_wreg(x_in_wreg), .in_wdata(x_in_wdata), .in_aux(x_in_aux),
        .out_valid(x_out_valid), .out_ready(x_out_ready),
        .out_wd(x_out_wd), .out_wreg(x_out_wreg), .out_wdata(x_out_wdata), .out_aux(x_out_aux),
        .occupancy(x_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive0(input logic v, input logic [4:0] wd, input logic wr,
                          input logic [31:0] wdata, input logic [7:0] aux);
        in_valid = v;
        in_wd    = wd;
        in_wreg  = wr;
        in_wdata = wdata;
        in_aux   = aux;
    endtask

    // One clock: handshakes are scored at the falling edge, then return 1 unit after the rising edge
    task automatic cycle();
        @(negedge clk);
        if (o0_out_valid && out_ready) begin
            check("sb0_queue_nonempty", 128'(q0.size() != 0), 128'(1));
            if (q0.size() != 0)
                check("sb0_beat", 128'({o0_out_wd, o0_out_wreg, o0_out_wdata, o0_out_aux}),
                      128'(q0.pop_front()));
        end
        if (flush) q0.delete();
        else if (in_valid && o0_in_ready) q0.push_back({in_wd, in_wreg, in_wdata, in_aux});
        if (x_out_valid && x_out_ready) begin
            n2_recv++;
            check("sb2_queue_nonempty", 128'(q2.size() != 0), 128'(1));
            if (q2.size() != 0)
                check("sb2_beat", 128'({x_out_wd, x_out_wreg, x_out_wdata, x_out_aux}),
                      128'(q2.pop_front()));
        end
        if (x_in_valid && x_in_ready) begin
            q2.push_back({x_in_wd, x_in_wreg, x_in_wdata, x_in_aux});
            n2_sent++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive2();
        if (n2_sent % 3 == 0) begin
            x_in_wd    = '1;
            x_in_wreg  = 1'b1;
            x_in_wdata = '1;
            x_in_aux   = '1;
        end else begin
            x_in_wd    = 6'(n2_sent);
            x_in_wreg  = n2_sent[0];
            x_in_wdata = {32'(n2_sent), ~32'(n2_sent)};
            x_in_aux   = n2_sent[1];
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive0(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 8'h00);
        x_flush = 1'b0; x_in_valid = 1'b0; x_out_ready = 1'b0;
        x_in_wd = '0; x_in_wreg = 1'b0; x_in_wdata = '0; x_in_aux = '0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #2;
        check("rst_async_out_valid", 128'(o0_out_valid), 128'(0));
        check("rst_async_in_ready", 128'(o0_in_ready), 128'(0));
        check("rst_async_occ", 128'(o0_occ), 128'(0));
        check("rst_async_payload", 128'({o0_out_wd, o0_out_wreg, o0_out_wdata, o0_out_aux}), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        check("rst_held_in_ready", 128'(o0_in_ready), 128'(0));
        rst = 1'b1;
        drive0(1'b0, 5'd0, 1'b0, 32'h0, 8'h00);
        cycle();
        check("rst_release_in_ready", 128'(o0_in_ready), 128'(1));
        check("rst_release_out_valid", 128'(o0_out_valid), 128'(0));

        // Streaming at one beat per cycle
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive0(1'b1, 5'(k), 1'b1, 32'(k), 8'(k));
            cycle();
            check("stream_out_valid", 128'(o0_out_valid), 128'(1));
            check("stream_out_wdata", 128'(o0_out_wdata), 128'(k));
            check("stream_occ", 128'(o0_occ), 128'(1));
            check("stream_in_ready", 128'(o0_in_ready), 128'(1));
        end
        drive0(1'b0, 5'd0, 1'b0, 32'h0, 8'h00);
        cycle();
        check("stream_end_occ", 128'(o0_occ), 128'(0));
        check("stream_end_zero_wdata", 128'(o0_out_wdata), 128'(0));
        check("stream_end_hold_wdata", 128'(o1_out_wdata), 128'(8));
        check("stream_end_hold_wreg", 128'(o1_out_wreg), 128'(0));

        // Backpressure fills main then skid
        out_ready = 1'b0;
        drive0(1'b1, 5'd10, 1'b1, 32'hA, 8'hA1);
        cycle();
        check("bp_occ1", 128'(o0_occ), 128'(1));
        check("bp_in_ready1", 128'(o0_in_ready), 128'(1));
        drive0(1'b1, 5'd11, 1'b1, 32'hB, 8'hB1);
        cycle();
        check("bp_occ2", 128'(o0_occ), 128'(2));
        check("bp_in_ready_full", 128'(o0_in_ready), 128'(0));
        check("bp_wdata_a", 128'(o0_out_wdata), 128'(32'hA));
        drive0(1'b0, 5'd0, 1'b0, 32'h0, 8'h00);
        cycle();
        check("bp_stall_wdata", 128'(o0_out_wdata), 128'(32'hA));
        check("bp_stall_wd", 128'(o0_out_wd), 128'(10));
        out_ready = 1'b1;
        cycle();
        check("bp_drain1_wdata", 128'(o0_out_wdata), 128'(32'hB));
        check("bp_drain1_occ", 128'(o0_occ), 128'(1));
        check("bp_drain1_in_ready", 128'(o0_in_ready), 128'(1));
        cycle();
        check("bp_drain2_occ", 128'(o0_occ), 128'(0));
        check("bp_drain2_out_valid", 128'(o0_out_valid), 128'(0));

        // Flush while FULL with a new beat offered
        out_ready = 1'b0;
        drive0(1'b1, 5'd1, 1'b1, 32'h21, 8'h00);
        cycle();
        drive0(1'b1, 5'd2, 1'b1, 32'h22, 8'h00);
        cycle();
        check("fl_full_occ", 128'(o0_occ), 128'(2));
        drive0(1'b1, 5'd12, 1'b1, 32'hC, 8'h0C);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive0(1'b0, 5'd0, 1'b0, 32'h0, 8'h00);
        check("fl_occ", 128'(o0_occ), 128'(0));
        check("fl_out_valid", 128'(o0_out_valid), 128'(0));
        check("fl_out_wreg", 128'(o0_out_wreg), 128'(0));
        check("fl_out_wd", 128'(o0_out_wd), 128'(0));
        check("fl_in_ready", 128'(o0_in_ready), 128'(1));
        check("fl_hold_out_wreg", 128'(o1_out_wreg), 128'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("fl_no_reappear", 128'(o0_out_valid), 128'(0));
        end

        // Flush in ONE with a simultaneous drain and accept
        drive0(1'b1, 5'd5, 1'b1, 32'h55, 8'h05);
        cycle();
        check("fl1_occ_before", 128'(o0_occ), 128'(1));
        drive0(1'b1, 5'd12, 1'b1, 32'hC, 8'h0C);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive0(1'b0, 5'd0, 1'b0, 32'h0, 8'h00);
        check("fl1_occ", 128'(o0_occ), 128'(0));
        cycle();
        check("fl1_no_reappear", 128'(o0_out_valid), 128'(0));

        // Bubble after a single beat: zeroing versus holding payload
        drive0(1'b1, 5'd3, 1'b1, 32'h33, 8'h07);
        cycle();
        check("bub_out_wd", 128'(o0_out_wd), 128'(3));
        check("bub_out_wreg", 128'(o0_out_wreg), 128'(1));
        drive0(1'b0, 5'd0, 1'b0, 32'h0, 8'h00);
        cycle();
        check("bub_zero_wd", 128'(o0_out_wd), 128'(0));
        check("bub_zero_wreg", 128'(o0_out_wreg), 128'(0));
        check("bub_hold_valid", 128'(o1_out_valid), 128'(0));
        check("bub_hold_wd", 128'(o1_out_wd), 128'(3));
        check("bub_hold_wreg", 128'(o1_out_wreg), 128'(0));
        check("bub_hold_wdata", 128'(o1_out_wdata), 128'(32'h33));
        check("bub_hold_aux", 128'(o1_out_aux), 128'(8'h07));

        // Reset asserted while a beat is held
        out_ready = 1'b0;
        drive0(1'b1, 5'd4, 1'b1, 32'h44, 8'h44);
        cycle();
        check("rmid_occ_before", 128'(o0_occ), 128'(1));
        drive0(1'b0, 5'd0, 1'b0, 32'h0, 8'h00);
        #2 rst = 1'b0;
        #1;
        q0.delete();
        check("rmid_out_valid", 128'(o0_out_valid), 128'(0));
        check("rmid_occ", 128'(o0_occ), 128'(0));
        check("rmid_wdata", 128'(o0_out_wdata), 128'(0));
        check("rmid_in_ready", 128'(o0_in_ready), 128'(0));
        #2 rst = 1'b1;
        cycle();
        check("rmid_release_in_ready", 128'(o0_in_ready), 128'(1));
        check("rmid_release_out_valid", 128'(o0_out_valid), 128'(0));

        // Wide instance under random valid/ready
        for (int k = 0; k < 300; k++) begin
            x_in_valid  = 1'($urandom_range(0, 1));
            x_out_ready = ($urandom_range(0, 3) != 0);
            drive2();
            cycle();
        end
        x_in_valid  = 1'b0;
        x_out_ready = 1'b1;
        for (int k = 0; k < 10 && q2.size() != 0; k++) cycle();
        check("x_queue_drained", 128'(q2.size()), 128'(0));
        check("x_recv_count", 128'(n2_recv), 128'(n2_sent));
        check("x_enough_beats", 128'(n2_sent > 40), 128'(1));
        check("x_occ_end", 128'(x_occ), 128'(0));
        check("sb0_all_drained", 128'(q0.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM latch.
- Registered pipeline stage carrying a writeback bundle (dest addr, write-enable, data, aux sideband) between any two pipeline stages.
- Adds a valid/ready handshake, a one-entry skid buffer so that in_ready is registered, a synchronous flush, and an occupancy output.
- Used for EX/MEM, MEM/WB and future stage boundaries.

Parameters:
- DATA_W, 32: width of the wdata field.
- ADDR_W, 5: width of the destination register address.
- AUX_W, 8: width of the opaque sideband (mem op, hi/lo flags); 1 minimum.
- ZERO_ON_EMPTY, 1: 1 = payload outputs cleared to NOP values whenever out_valid=0; 0 = payload holds last value, and only out_wreg is forced to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat; registered, state decode only.
- in_wd  in  ADDR_W  destination register address.
- in_wreg  in  1  register write enable.
- in_wdata  in  DATA_W  result data.
- in_aux  in  AUX_W  sideband.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_wd  out  ADDR_W  held address.
- out_wreg  out  1  held write enable; always 0 when out_valid=0.
- out_wdata  out  DATA_W  held data.
- out_aux  out  AUX_W  held sideband.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage is a main register, which drives the out_* ports, plus a skid register. out_* is a pure register output with no combinational path from in_*.
- States: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
- in_ready = (state != FULL). It never depends combinationally on out_ready or in_valid.
- EMPTY: on accept, main <= in and go to ONE. Otherwise outputs hold NOP values.
- ONE:
  - accept & drain: main <= in, stay in ONE (full throughput, 1 beat/cycle).
  - accept & !drain: skid <= in, go to FULL.
  - !accept & drain: go to EMPTY.
  - Otherwise hold.
- FULL: in_ready=0. On drain, main <= skid and go to ONE. Otherwise hold, and out_* must stay stable while out_valid=1 & !out_ready.
- Latency: a beat accepted at edge N is visible on out_* after edge N when the stage was EMPTY, or when it was ONE and drained in the same cycle. A skidded beat appears after the edge on which the preceding beat drains.
- Ordering is strict FIFO; no beat is dropped or duplicated except by flush.
- NOP values: out_wd=0, out_wreg=0, out_wdata=0, out_aux=0.
- Reset (rst=0, asynchronous, no clock needed):
  - state EMPTY, occupancy=0, out_valid=0, in_ready=0.
  - All payload outputs at NOP values; skid cleared.
  - in_ready rises on the first clk edge after rst deasserts.
  - Reset asserted mid-transfer discards all held beats immediately.
- flush: highest priority at the clock edge.
  - Next state EMPTY; out_valid=0, out_wreg=0; payload NOP when ZERO_ON_EMPTY=1.
  - Any beat whose handshake completes in the flush cycle is discarded.
  - A drain completing in the flush cycle counts as consumed downstream.
  - Flush while FULL clears both entries.
- ZERO_ON_EMPTY=0: on any transition to EMPTY, out_wd/out_wdata/out_aux keep their last values; out_wreg still goes to 0.
- occupancy is registered and equals the state encoding.

Test Plan:
- Reset: hold rst=0 with in_valid=1, in_wd=5, in_wreg=1, in_wdata=0xDEADBEEF, mid-clock -> outputs 0, out_valid=0, in_ready=0 asynchronously. After release and one edge, in_ready=1.
- Streaming: out_ready=1, in_valid=1 every cycle, wdata=1,2,3,... -> out_wdata follows with 1-cycle latency, out_valid continuous, occupancy=1, in_ready never drops.
- Backpressure: send wdata 0xA then 0xB with out_ready=0 -> occupancy 1 then 2, in_ready=0, out_wdata stays 0xA. Raise out_ready -> 0xA drains, then 0xB, occupancy 2→1→0, in_ready returns to 1 the cycle after the first drain.
- Flush while FULL with in_valid=1 (wdata=0xC) -> next cycle occupancy=0, out_valid=0, out_wreg=0, out_wd=0; 0xC never appears on the output.
- Bubble: single beat wd=3, wreg=1, followed by in_valid=0 -> after drain out_wreg=0 and out_wd=0 (ZERO_ON_EMPTY=1). Rerun with ZERO_ON_EMPTY=0 -> out_wd stays 3, out_wreg=0.
- Widths: DATA_W=64, ADDR_W=6, AUX_W=1, all-ones payload passed under random in_valid/out_ready -> bit-exact FIFO order against a scoreboard, no loss or duplication.
